// File: rtl/kappa3_ctl_pkg.sv
// Shared encodings for the KAPPA3 sequencing control unit: states, ALU
// control codes, RV32I opcode/funct3 values and the rd write-back select.
package kappa3_ctl_pkg;

   typedef enum logic [2:0] {
      S_HALT = 3'd0,
      S_IF   = 3'd1,
      S_DE   = 3'd2,
      S_EX   = 3'd3,
      S_BR   = 3'd4,
      S_MA   = 3'd5,
      S_WB   = 3'd6,
      S_ERR  = 3'd7
   } state_t;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_EQ    = 4'd10;
   localparam logic [3:0] ALU_NE    = 4'd11;
   localparam logic [3:0] ALU_GE    = 4'd12;
   localparam logic [3:0] ALU_GEU   = 4'd13;
   localparam logic [3:0] ALU_PASSB = 4'd14;

   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] RD_C   = 2'b00;
   localparam logic [1:0] RD_MEM = 2'b01;
   localparam logic [1:0] RD_PC4 = 2'b10;

   function automatic logic legal_opcode(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
         OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // BLT/BLTU reuse the set-less-than codes: bit 0 of the result is the condition.
   function automatic logic [3:0] br_op(input logic [2:0] f3);
      case (f3)
         F3_BNE:  return ALU_NE;
         F3_BLT:  return ALU_SLT;
         F3_BGE:  return ALU_GE;
         F3_BLTU: return ALU_SLTU;
         F3_BGEU: return ALU_GEU;
         default: return ALU_EQ;
      endcase
   endfunction

endpackage

// File: rtl/seq_controller_imm_gen.sv
// RV32I immediate extraction: I/S/B/U/J formats selected by opcode, sign-extended.
module imm_gen
   import kappa3_ctl_pkg::*;
(
   input  logic [31:0] ir,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (ir[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_MISC_MEM:
            imm = {{20{ir[31]}}, ir[31:20]};
         OP_STORE:
            imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OP_BRANCH:
            imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {ir[31:12], 12'b0};
         OP_JAL:
            imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/seq_controller.sv
// KAPPA3 multi-cycle control unit: phase sequencing, memory handshake with
// timeout, run/step/halt control, fault trapping and datapath control decode.
module seq_controller
   import kappa3_ctl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT   = 255,
   parameter int unsigned TMO_W         = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1),
   parameter bit          START_RUNNING = 1'b1,
   parameter bit          MISALIGN_TRAP = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic        step,
   input  logic [31:0] ir,
   input  logic [31:0] addr,
   input  logic [31:0] alu_out,
   input  logic        mem_ready,
   output logic        pc_sel,
   output logic        pc_ld,
   output logic        mem_sel,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_wrbits,
   output logic        ir_ld,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic [4:0]  rd_addr,
   output logic [1:0]  rd_sel,
   output logic        rd_ld,
   output logic        a_ld,
   output logic        b_ld,
   output logic        a_sel,
   output logic        b_sel,
   output logic [31:0] imm,
   output logic [3:0]  alu_ctl,
   output logic        c_ld,
   output logic [2:0]  phase,
   output logic        halted,
   output logic        fault
);

   state_t           state, state_nx, fetch_st;
   logic             one_shot, one_shot_nx;
   logic [TMO_W-1:0] wait_cnt;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             is_load, is_store, is_jump, misaligned, tmo_hit;
   logic [3:0]       wrbits;
   logic             unused_bits;

   assign opcode   = ir[6:0];
   assign funct3   = ir[14:12];
   assign rs1_addr = ir[19:15];
   assign rs2_addr = ir[24:20];
   assign rd_addr  = ir[11:7];
   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
   assign fetch_st = (run && !one_shot) ? S_IF : S_HALT;
   assign tmo_hit  = (MEM_TIMEOUT != 0) && (wait_cnt == TMO_W'(MEM_TIMEOUT - 1));
   assign unused_bits = ^{addr[31:2], alu_out[31:1]};

   imm_gen u_imm_gen (
      .ir  (ir),
      .imm (imm)
   );

   always_comb begin
      misaligned = 1'b0;
      wrbits     = '0;
      case (funct3[1:0])
         2'b00: wrbits = 4'b0001 << addr[1:0];
         2'b01: begin
            wrbits     = addr[1] ? 4'b1100 : 4'b0011;
            misaligned = addr[0];
         end
         2'b10: begin
            wrbits     = 4'b1111;
            misaligned = (addr[1:0] != 2'b00);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= START_RUNNING ? S_IF : S_HALT;
         one_shot <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         one_shot <= one_shot_nx;
         if (state_nx != state)
            wait_cnt <= '0;
         else if ((state == S_IF || state == S_MA) && !mem_ready && MEM_TIMEOUT != 0)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx    = state;
      one_shot_nx = one_shot;
      pc_sel      = 1'b0;
      pc_ld       = 1'b0;
      mem_sel     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_wrbits  = '0;
      ir_ld       = 1'b0;
      rd_sel      = RD_C;
      rd_ld       = 1'b0;
      a_ld        = 1'b0;
      b_ld        = 1'b0;
      a_sel       = 1'b0;
      b_sel       = 1'b0;
      alu_ctl     = ALU_ADD;
      c_ld        = 1'b0;

      case (state)
         S_HALT: begin
            if (run) begin
               state_nx = S_IF;
            end else if (step) begin
               state_nx    = S_IF;
               one_shot_nx = 1'b1;
            end
         end
         S_IF: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_ld    = 1'b1;
               state_nx = S_DE;
            end else if (tmo_hit) begin
               state_nx = S_ERR;
            end
         end
         S_DE: begin
            a_ld     = 1'b1;
            b_ld     = 1'b1;
            state_nx = legal_opcode(opcode) ? S_EX : S_ERR;
         end
         S_EX: begin
            c_ld = 1'b1;
            case (opcode)
               OP_OP:  alu_ctl = alu_op(funct3, ir[30]);
               OP_IMM: begin
                  b_sel   = 1'b1;
                  alu_ctl = alu_op(funct3, ir[30] && (funct3 == F3_SR));
               end
               OP_LOAD, OP_STORE, OP_JALR: b_sel = 1'b1;
               OP_LUI: begin
                  b_sel   = 1'b1;
                  alu_ctl = ALU_PASSB;
               end
               OP_AUIPC, OP_JAL, OP_BRANCH: begin
                  a_sel = 1'b1;
                  b_sel = 1'b1;
               end
               default: ;
            endcase
            if (opcode == OP_BRANCH)
               state_nx = S_BR;
            else if (is_load || is_store)
               state_nx = (misaligned && MISALIGN_TRAP) ? S_ERR : S_MA;
            else
               state_nx = S_WB;
         end
         S_BR: begin
            alu_ctl     = br_op(funct3);
            pc_sel      = alu_out[0];
            pc_ld       = 1'b1;
            state_nx    = fetch_st;
            one_shot_nx = 1'b0;
         end
         S_MA: begin
            mem_sel = 1'b1;
            if (is_load) begin
               mem_read = 1'b1;
            end else begin
               mem_write  = 1'b1;
               mem_wrbits = wrbits;
            end
            if (mem_ready) begin
               if (is_load) begin
                  state_nx = S_WB;
               end else begin
                  pc_ld       = 1'b1;
                  state_nx    = fetch_st;
                  one_shot_nx = 1'b0;
               end
            end else if (tmo_hit) begin
               state_nx = S_ERR;
            end
         end
         S_WB: begin
            pc_ld       = 1'b1;
            one_shot_nx = 1'b0;
            if (opcode == OP_SYSTEM) begin
               state_nx = S_HALT;
            end else begin
               rd_ld    = (rd_addr != 5'd0);
               rd_sel   = is_load ? RD_MEM : (is_jump ? RD_PC4 : RD_C);
               pc_sel   = is_jump;
               state_nx = fetch_st;
            end
         end
         S_ERR: ;
         default: state_nx = S_ERR;
      endcase

      // Reset lands mid-cycle on whatever state is current; kill every strobe so an
      // interrupted access never completes a load or write.
      if (reset) begin
         pc_sel     = 1'b0;
         pc_ld      = 1'b0;
         mem_sel    = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         mem_wrbits = '0;
         ir_ld      = 1'b0;
         rd_ld      = 1'b0;
         a_ld       = 1'b0;
         b_ld       = 1'b0;
         c_ld       = 1'b0;
      end
   end

   assign phase  = state;
   assign halted = (state == S_HALT);
   assign fault  = (state == S_ERR) && !reset;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller (MEM_TIMEOUT=4, START_RUNNING=0): a cycle
// table for the main instruction flows plus sequences for faults and reset.
module tb_seq_controller;

   localparam logic [2:0] P_HALT = 3'd0, P_IF = 3'd1, P_DE = 3'd2, P_EX = 3'd3,
                          P_BR = 3'd4, P_MA = 3'd5, P_WB = 3'd6, P_ERR = 3'd7;
   localparam logic [3:0] A_ADD = 4'd0, A_EQ = 4'd10;

   // strobe word: {pc_sel,pc_ld,mem_sel,mem_read,mem_write,ir_ld,rd_ld,a_ld,b_ld,a_sel,b_sel,c_ld}
   localparam logic [11:0] PCSEL = 12'h800, PCLD = 12'h400, MSEL = 12'h200, MRD = 12'h100,
                           MWR = 12'h080, IRLD = 12'h040, RDLD = 12'h020, ALD = 12'h010,
                           BLD = 12'h008, ASEL = 12'h004, BSEL = 12'h002, CLD = 12'h001,
                           NONE = 12'h000;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SB    = 32'h00208023;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_ADDI  = 32'hFFF08293;
   localparam logic [31:0] I_JAL   = 32'hFFDFF0EF;
   localparam logic [31:0] I_ECALL = 32'h00000073;
   localparam logic [31:0] I_LW    = 32'h0000A183;
   localparam logic [31:0] I_SWN   = 32'hFE20AC23;
   localparam logic [31:0] I_BNEN  = 32'hFE2098E3;
   localparam logic [31:0] I_LUI   = 32'h123450B7;

   typedef struct {
      string       name;
      logic        run;
      logic        step;
      logic [31:0] ir;
      logic [31:0] addr;
      logic        alu0;
      logic        rdy;
      logic [2:0]  ph;
      logic [11:0] strb;
      logic [1:0]  rsel;
      logic [3:0]  wrb;
      logic [3:0]  alu;
   } vec_t;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] imm;
   } imm_vec_t;

   logic        clock = 1'b0;
   logic        reset, run, step, mem_ready;
   logic [31:0] ir, addr, alu_out;
   logic        pc_sel, pc_ld, mem_sel, mem_read, mem_write, ir_ld;
   logic [3:0]  mem_wrbits, alu_ctl;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [1:0]  rd_sel;
   logic        rd_ld, a_ld, b_ld, a_sel, b_sel, c_ld, halted, fault;
   logic [31:0] imm;
   logic [2:0]  phase;

   int n_cmp = 0;
   int n_bad = 0;

   vec_t     tbl[$];
   imm_vec_t itbl[$];

   always #5 clock = ~clock;

   seq_controller #(
      .MEM_TIMEOUT   (4),
      .START_RUNNING (1'b0),
      .MISALIGN_TRAP (1'b1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .step       (step),
      .ir         (ir),
      .addr       (addr),
      .alu_out    (alu_out),
      .mem_ready  (mem_ready),
      .pc_sel     (pc_sel),
      .pc_ld      (pc_ld),
      .mem_sel    (mem_sel),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_wrbits (mem_wrbits),
      .ir_ld      (ir_ld),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rd_addr    (rd_addr),
      .rd_sel     (rd_sel),
      .rd_ld      (rd_ld),
      .a_ld       (a_ld),
      .b_ld       (b_ld),
      .a_sel      (a_sel),
      .b_sel      (b_sel),
      .imm        (imm),
      .alu_ctl    (alu_ctl),
      .c_ld       (c_ld),
      .phase      (phase),
      .halted     (halted),
      .fault      (fault)
   );

   function automatic vec_t mkv(string nm, logic r, logic s, logic [31:0] i, logic [31:0] a,
                                logic al, logic rd, logic [2:0] ph, logic [11:0] st,
                                logic [1:0] rs = 2'b00, logic [3:0] wb = 4'b0000,
                                logic [3:0] alu = 4'd0);
      vec_t v;
      v.name = nm; v.run = r; v.step = s; v.ir = i; v.addr = a; v.alu0 = al; v.rdy = rd;
      v.ph = ph; v.strb = st; v.rsel = rs; v.wrb = wb; v.alu = alu;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      run       = v.run;
      step      = v.step;
      ir        = v.ir;
      addr      = v.addr;
      alu_out   = {31'b0, v.alu0};
      mem_ready = v.rdy;
   endtask

   task automatic check(input vec_t v);
      logic [11:0] s;
      s = {pc_sel, pc_ld, mem_sel, mem_read, mem_write, ir_ld, rd_ld, a_ld, b_ld, a_sel, b_sel, c_ld};
      n_cmp++;
      if (phase !== v.ph || s !== v.strb || rd_sel !== v.rsel || mem_wrbits !== v.wrb ||
          alu_ctl !== v.alu || halted !== (v.ph == P_HALT) || fault !== (v.ph == P_ERR)) begin
         n_bad++;
         $display("FAIL %s: got phase=%0d strb=%03h rd_sel=%0d wrbits=%04b alu=%0d halted=%0b fault=%0b; want phase=%0d strb=%03h rd_sel=%0d wrbits=%04b alu=%0d",
                  v.name, phase, s, rd_sel, mem_wrbits, alu_ctl, halted, fault,
                  v.ph, v.strb, v.rsel, v.wrb, v.alu);
      end
   endtask

   task automatic apply(input vec_t v);
      drive(v);
      #1;
      check(v);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(mkv("rst", 0, 0, 32'h0, 32'h0, 0, 0, P_HALT, NONE));
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ADD, SB with delayed ready, BEQ taken/not taken, step, run+step, JAL, ECALL
      tbl.push_back(mkv("reset_halt", 0, 0, I_ADD, 0, 0, 0, P_HALT, NONE));
      tbl.push_back(mkv("halt_run",   1, 0, I_ADD, 0, 0, 0, P_HALT, NONE));
      tbl.push_back(mkv("add_if",     1, 0, I_ADD, 0, 0, 1, P_IF,   MRD | IRLD));
      tbl.push_back(mkv("add_de",     1, 0, I_ADD, 0, 0, 1, P_DE,   ALD | BLD));
      tbl.push_back(mkv("add_ex",     1, 0, I_ADD, 0, 0, 1, P_EX,   CLD, 2'b00, 4'b0000, A_ADD));
      tbl.push_back(mkv("add_wb",     1, 0, I_ADD, 0, 0, 1, P_WB,   RDLD | PCLD));
      tbl.push_back(mkv("sb_if",      1, 0, I_SB, 0, 0, 1, P_IF,    MRD | IRLD));
      tbl.push_back(mkv("sb_de",      1, 0, I_SB, 0, 0, 1, P_DE,    ALD | BLD));
      tbl.push_back(mkv("sb_ex",      1, 0, I_SB, 32'h1002, 0, 1, P_EX, BSEL | CLD));
      tbl.push_back(mkv("sb_wait1",   1, 0, I_SB, 32'h1002, 0, 0, P_MA, MSEL | MWR, 2'b00, 4'b0100));
      tbl.push_back(mkv("sb_wait2",   1, 0, I_SB, 32'h1002, 0, 0, P_MA, MSEL | MWR, 2'b00, 4'b0100));
      tbl.push_back(mkv("sb_wait3",   1, 0, I_SB, 32'h1002, 0, 0, P_MA, MSEL | MWR, 2'b00, 4'b0100));
      tbl.push_back(mkv("sb_ready",   1, 0, I_SB, 32'h1002, 0, 1, P_MA, MSEL | MWR | PCLD, 2'b00, 4'b0100));
      tbl.push_back(mkv("beq1_if",    1, 0, I_BEQ, 0, 0, 1, P_IF,   MRD | IRLD));
      tbl.push_back(mkv("beq1_de",    1, 0, I_BEQ, 0, 0, 1, P_DE,   ALD | BLD));
      tbl.push_back(mkv("beq1_ex",    1, 0, I_BEQ, 0, 0, 1, P_EX,   ASEL | BSEL | CLD));
      tbl.push_back(mkv("beq_taken",  1, 0, I_BEQ, 0, 1, 1, P_BR,   PCSEL | PCLD, 2'b00, 4'b0000, A_EQ));
      tbl.push_back(mkv("beq2_if",    1, 0, I_BEQ, 0, 0, 1, P_IF,   MRD | IRLD));
      tbl.push_back(mkv("beq2_de",    1, 0, I_BEQ, 0, 0, 1, P_DE,   ALD | BLD));
      tbl.push_back(mkv("beq2_ex",    1, 0, I_BEQ, 0, 0, 1, P_EX,   ASEL | BSEL | CLD));
      tbl.push_back(mkv("beq_nottkn", 0, 0, I_BEQ, 0, 0, 1, P_BR,   PCLD, 2'b00, 4'b0000, A_EQ));
      tbl.push_back(mkv("halt_idle",  0, 0, I_ADDI, 0, 0, 1, P_HALT, NONE));
      tbl.push_back(mkv("step_halt",  0, 1, I_ADDI, 0, 0, 1, P_HALT, NONE));
      tbl.push_back(mkv("step_if",    0, 0, I_ADDI, 0, 0, 1, P_IF,   MRD | IRLD));
      tbl.push_back(mkv("step_de",    0, 0, I_ADDI, 0, 0, 1, P_DE,   ALD | BLD));
      tbl.push_back(mkv("step_ex",    0, 0, I_ADDI, 0, 0, 1, P_EX,   BSEL | CLD));
      tbl.push_back(mkv("step_wb",    1, 0, I_ADDI, 0, 0, 1, P_WB,   RDLD | PCLD));
      tbl.push_back(mkv("step_halted",0, 0, I_ADD, 0, 0, 1, P_HALT, NONE));
      tbl.push_back(mkv("runstep",    1, 1, I_ADD, 0, 0, 1, P_HALT, NONE));
      tbl.push_back(mkv("rs_if",      1, 0, I_ADD, 0, 0, 1, P_IF,   MRD | IRLD));
      tbl.push_back(mkv("rs_de",      1, 0, I_ADD, 0, 0, 1, P_DE,   ALD | BLD));
      tbl.push_back(mkv("rs_ex",      1, 0, I_ADD, 0, 0, 1, P_EX,   CLD));
      tbl.push_back(mkv("rs_wb",      1, 0, I_ADD, 0, 0, 1, P_WB,   RDLD | PCLD));
      tbl.push_back(mkv("jal_if",     1, 0, I_JAL, 0, 0, 1, P_IF,   MRD | IRLD));
      tbl.push_back(mkv("jal_de",     1, 0, I_JAL, 0, 0, 1, P_DE,   ALD | BLD));
      tbl.push_back(mkv("jal_ex",     1, 0, I_JAL, 0, 0, 1, P_EX,   ASEL | BSEL | CLD));
      tbl.push_back(mkv("jal_wb",     1, 0, I_JAL, 0, 0, 1, P_WB,   RDLD | PCLD | PCSEL, 2'b10));
      tbl.push_back(mkv("ecall_if",   1, 0, I_ECALL, 0, 0, 1, P_IF, MRD | IRLD));
      tbl.push_back(mkv("ecall_de",   1, 0, I_ECALL, 0, 0, 1, P_DE, ALD | BLD));
      tbl.push_back(mkv("ecall_ex",   1, 0, I_ECALL, 0, 0, 1, P_EX, CLD));
      tbl.push_back(mkv("ecall_wb",   1, 0, I_ECALL, 0, 0, 1, P_WB, PCLD));
      tbl.push_back(mkv("ecall_halt", 0, 0, I_ECALL, 0, 0, 1, P_HALT, NONE));

      itbl.push_back('{I_ADD,  32'h00000000});
      itbl.push_back('{I_ADDI, 32'hFFFFFFFF});
      itbl.push_back('{I_SWN,  32'hFFFFFFF8});
      itbl.push_back('{I_BEQ,  32'h00000008});
      itbl.push_back('{I_BNEN, 32'hFFFFFFF0});
      itbl.push_back('{I_JAL,  32'hFFFFFFFC});
      itbl.push_back('{I_LUI,  32'h12345000});

      do_reset();
      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i]);

      // register fields and immediate decode
      ir = I_ADD;
      #1;
      n_cmp++;
      if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2 || rd_addr !== 5'd3) begin
         n_bad++;
         $display("FAIL fields: got rs1=%0d rs2=%0d rd=%0d; want 1 2 3", rs1_addr, rs2_addr, rd_addr);
      end
      for (int i = 0; i < itbl.size(); i++) begin
         ir = itbl[i].ir;
         #1;
         n_cmp++;
         if (imm !== itbl[i].imm) begin
            n_bad++;
            $display("FAIL imm[%0d] ir=%08h: got %08h want %08h", i, itbl[i].ir, imm, itbl[i].imm);
         end
      end

      // illegal opcode traps after decode; fault is sticky until reset
      do_reset();
      apply(mkv("ill_halt", 1, 0, 32'h0, 0, 0, 1, P_HALT, NONE));
      apply(mkv("ill_if",   1, 0, 32'h0, 0, 0, 1, P_IF,   MRD | IRLD));
      apply(mkv("ill_de",   1, 0, 32'h0, 0, 0, 1, P_DE,   ALD | BLD));
      apply(mkv("ill_err1", 1, 1, I_ADD, 0, 1, 1, P_ERR,  NONE));
      apply(mkv("ill_err2", 1, 1, I_ADD, 0, 1, 1, P_ERR,  NONE));
      do_reset();
      apply(mkv("ill_clear", 0, 0, I_ADD, 0, 0, 1, P_HALT, NONE));

      // misaligned LW traps from EX without a memory read
      do_reset();
      apply(mkv("lwm_halt", 1, 0, I_LW, 32'h1001, 0, 1, P_HALT, NONE));
      apply(mkv("lwm_if",   1, 0, I_LW, 32'h1001, 0, 1, P_IF,   MRD | IRLD));
      apply(mkv("lwm_de",   1, 0, I_LW, 32'h1001, 0, 1, P_DE,   ALD | BLD));
      apply(mkv("lwm_ex",   1, 0, I_LW, 32'h1001, 0, 1, P_EX,   BSEL | CLD));
      apply(mkv("lwm_err",  1, 0, I_LW, 32'h1001, 0, 1, P_ERR,  NONE));

      // aligned LW completes through MA and WB
      do_reset();
      apply(mkv("lw_halt", 1, 0, I_LW, 32'h1000, 0, 1, P_HALT, NONE));
      apply(mkv("lw_if",   1, 0, I_LW, 32'h1000, 0, 1, P_IF,   MRD | IRLD));
      apply(mkv("lw_de",   1, 0, I_LW, 32'h1000, 0, 1, P_DE,   ALD | BLD));
      apply(mkv("lw_ex",   1, 0, I_LW, 32'h1000, 0, 1, P_EX,   BSEL | CLD));
      apply(mkv("lw_ma",   1, 0, I_LW, 32'h1000, 0, 1, P_MA,   MSEL | MRD));
      apply(mkv("lw_wb",   0, 0, I_LW, 32'h1000, 0, 1, P_WB,   RDLD | PCLD, 2'b01));
      apply(mkv("lw_halt2",0, 0, I_LW, 32'h1000, 0, 1, P_HALT, NONE));

      // fetch timeout: four waiting IF cycles, then ERR
      do_reset();
      apply(mkv("tmo_halt", 1, 0, I_ADD, 0, 0, 0, P_HALT, NONE));
      for (int i = 0; i < 4; i++)
         apply(mkv($sformatf("tmo_wait%0d", i), 1, 0, I_ADD, 0, 0, 0, P_IF, MRD));
      apply(mkv("tmo_err", 1, 0, I_ADD, 0, 0, 1, P_ERR, NONE));

      // reset during a store access aborts it
      do_reset();
      apply(mkv("rma_halt", 1, 0, I_SB, 32'h1000, 0, 1, P_HALT, NONE));
      apply(mkv("rma_if",   1, 0, I_SB, 32'h1000, 0, 1, P_IF,   MRD | IRLD));
      apply(mkv("rma_de",   1, 0, I_SB, 32'h1000, 0, 1, P_DE,   ALD | BLD));
      apply(mkv("rma_ex",   1, 0, I_SB, 32'h1000, 0, 1, P_EX,   BSEL | CLD));
      apply(mkv("rma_ma",   1, 0, I_SB, 32'h1000, 0, 0, P_MA,   MSEL | MWR, 2'b00, 4'b0001));
      drive(mkv("rma_rst", 0, 0, I_SB, 32'h1000, 0, 1, P_MA, NONE));
      reset = 1'b1;
      #1;
      check(mkv("rma_rst", 0, 0, I_SB, 32'h1000, 0, 1, P_MA, NONE));
      @(posedge clock);
      #1;
      reset = 1'b0;
      apply(mkv("rma_after", 0, 0, I_SB, 32'h1000, 0, 1, P_HALT, NONE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
